// File: rtl/csi_tx_packetizer.sv
// Two-lane MIPI CSI-2 transmit packetizer: turns FS/FE requests and AXI-Stream pixel lines
// into short and long packets (header+ECC, payload, CRC-16 footer) on a D-PHY PPI TX interface.
module csi_tx_packetizer #(
    parameter logic [1:0] VC = 2'd0
) (
    input  logic        i_txbyteclkhs,
    input  logic        i_txbyteclkhs_reset,
    input  logic [5:0]  i_cfg_data_type,
    input  logic [15:0] i_cfg_word_count,
    input  logic        i_fs_req,
    input  logic        i_fe_req,
    input  logic        i_s_axis_tvalid,
    output logic        o_s_axis_tready,
    input  logic [15:0] i_s_axis_tdata,
    input  logic        i_s_axis_tlast,
    output logic        o_ppi_txrequesths,
    input  logic        i_ppi_txreadyhs,
    output logic [7:0]  o_ppi_dl0_txdatahs,
    output logic [7:0]  o_ppi_dl1_txdatahs,
    output logic        o_busy,
    output logic        o_err_underflow,
    output logic        o_err_length
);

    typedef enum logic [2:0] {IDLE, SP0, SP1, LP0, LP1, PAYLOAD, FOOTER, GAP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_txreq;
    logic        r_fs_pend;
    logic        r_fe_pend;
    logic        r_pad;
    logic        r_discard;
    logic        r_err_underflow;
    logic        r_err_length;
    logic [7:0]  r_di;
    logic [7:0]  r_ecc;
    logic [15:0] r_wc;
    logic [15:0] r_crc;
    logic [14:0] r_beats;

    logic        w_start_fs;
    logic        w_start_fe;
    logic        w_start_lp;
    logic        w_beat;
    logic        w_last_beat;
    logic        w_tready;
    logic [7:0]  w_sp_di;
    logic [15:0] w_pay;
    logic [15:0] w_lanes;

    // Hamming parity over {WC, DI}; each mask selects the data bits feeding one parity bit.
    function automatic logic [7:0] eccCalc(input logic [23:0] d);
        return {2'b00,
                ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 16'h8408) : (x >> 1);
        end
        return x;
    endfunction

    assign w_sp_di = w_start_fs ? {VC, 6'h00} : {VC, 6'h01};

    always_comb begin
        w_next      = r_state;
        w_start_fs  = 1'b0;
        w_start_fe  = 1'b0;
        w_start_lp  = 1'b0;
        w_beat      = 1'b0;
        w_tready    = 1'b0;
        w_lanes     = 16'h0000;
        w_last_beat = (r_beats == 15'd1);
        w_pay       = (r_pad || !i_s_axis_tvalid) ? 16'h0000 : i_s_axis_tdata;
        case (r_state)
            IDLE: begin
                if (r_fs_pend) begin
                    w_start_fs = 1'b1;
                    w_next     = SP0;
                end else if (i_s_axis_tvalid) begin
                    w_start_lp = 1'b1;
                    w_next     = LP0;
                end else if (r_fe_pend) begin
                    w_start_fe = 1'b1;
                    w_next     = SP0;
                end
            end
            SP0: begin
                w_lanes = {8'h00, r_di};
                if (i_ppi_txreadyhs) w_next = SP1;
            end
            SP1: begin
                w_lanes = {r_ecc, 8'h00};
                if (i_ppi_txreadyhs) w_next = GAP;
            end
            LP0: begin
                w_lanes = {r_wc[7:0], r_di};
                if (i_ppi_txreadyhs) w_next = LP1;
            end
            LP1: begin
                w_lanes = {r_ecc, r_wc[15:8]};
                if (i_ppi_txreadyhs) w_next = (r_beats == 15'd0) ? FOOTER : PAYLOAD;
            end
            PAYLOAD: begin
                w_lanes  = w_pay;
                w_tready = i_ppi_txreadyhs && !r_pad;
                if (i_ppi_txreadyhs) begin
                    w_beat = 1'b1;
                    if (w_last_beat) w_next = FOOTER;
                end
            end
            FOOTER: begin
                w_lanes = r_crc;
                if (i_ppi_txreadyhs) w_next = GAP;
            end
            GAP: begin
                // An over-long line is drained here until its tlast is seen.
                w_tready = r_discard;
                if (!r_discard || (i_s_axis_tvalid && i_s_axis_tlast)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_txbyteclkhs or posedge i_txbyteclkhs_reset) begin
        if (i_txbyteclkhs_reset) begin
            r_state         <= IDLE;
            r_txreq         <= 1'b0;
            r_fs_pend       <= 1'b0;
            r_fe_pend       <= 1'b0;
            r_pad           <= 1'b0;
            r_discard       <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_length    <= 1'b0;
            r_di            <= 8'h00;
            r_ecc           <= 8'h00;
            r_wc            <= 16'h0000;
            r_crc           <= 16'hFFFF;
            r_beats         <= 15'd0;
        end else begin
            r_state   <= w_next;
            r_txreq   <= (w_next != IDLE) && (w_next != GAP);
            r_fs_pend <= r_fs_pend ? !w_start_fs : i_fs_req;
            r_fe_pend <= r_fe_pend ? !w_start_fe : i_fe_req;
            if (w_start_fs || w_start_fe) begin
                r_di  <= w_sp_di;
                r_wc  <= 16'h0000;
                r_ecc <= eccCalc({16'h0000, w_sp_di});
            end else if (w_start_lp) begin
                r_di      <= {VC, i_cfg_data_type};
                r_wc      <= i_cfg_word_count;
                r_ecc     <= eccCalc({i_cfg_word_count, VC, i_cfg_data_type});
                r_beats   <= i_cfg_word_count[15:1];
                r_crc     <= 16'hFFFF;
                r_pad     <= 1'b0;
                r_discard <= 1'b0;
            end
            if (w_beat) begin
                r_crc   <= crcByte(crcByte(r_crc, w_pay[7:0]), w_pay[15:8]);
                r_beats <= r_beats - 15'd1;
                if (!r_pad) begin
                    if (!i_s_axis_tvalid) begin
                        r_err_underflow <= 1'b1;
                    end else if (i_s_axis_tlast && !w_last_beat) begin
                        r_pad        <= 1'b1;
                        r_err_length <= 1'b1;
                    end
                    if (w_last_beat && !(i_s_axis_tvalid && i_s_axis_tlast)) begin
                        r_err_length <= 1'b1;
                        r_discard    <= 1'b1;
                    end
                end
            end
            if (r_state == GAP && r_discard && i_s_axis_tvalid && i_s_axis_tlast) begin
                r_discard <= 1'b0;
            end
        end
    end

    assign o_ppi_txrequesths  = r_txreq;
    assign o_ppi_dl0_txdatahs = w_lanes[7:0];
    assign o_ppi_dl1_txdatahs = w_lanes[15:8];
    assign o_s_axis_tready    = w_tready;
    assign o_busy             = (r_state != IDLE);
    assign o_err_underflow    = r_err_underflow;
    assign o_err_length       = r_err_length;

endmodule

// File: tb/tb_csi_tx_packetizer.sv
// Directed self-checking bench for csi_tx_packetizer: short packets, long lines, PHY
// backpressure, stream underflow, short/over-long lines, request ordering and mid-packet reset.
`timescale 1ns/1ps
module tb_csi_tx_packetizer;

   typedef logic [15:0] wq_t[$];

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  cfgDt;
   logic [15:0] cfgWc;
   logic        fsReq, feReq;
   logic        tvalid, tready, tlast;
   logic [15:0] tdata;
   logic        txreq, readyhs;
   logic [7:0]  dl0, dl1;
   logic        busy, errUnder, errLen;

   int checks = 0;
   int errors = 0;

   // Source state shared between the traffic driver and the scenario tasks
   wq_t srcData;
   int  srcLastIdx = -1;
   int  srcIdx = 0;
   int  dropIdx = -1;
   int  dropLeft = 0;
   bit  randReady = 0;

   logic [15:0] lineBeats [0:11] = '{16'h00FF, 16'h0200, 16'hDCB9, 16'h72F3, 16'hD4BB, 16'h5AB8,
                                      16'h75C8, 16'h7CC2, 16'hF881, 16'hDF05, 16'h00FF, 16'h0100};

   always #5 clock = ~clock;

   csi_tx_packetizer dut (
      .i_txbyteclkhs       (clock),
      .i_txbyteclkhs_reset (reset),
      .i_cfg_data_type     (cfgDt),
      .i_cfg_word_count    (cfgWc),
      .i_fs_req            (fsReq),
      .i_fe_req            (feReq),
      .i_s_axis_tvalid     (tvalid),
      .o_s_axis_tready     (tready),
      .i_s_axis_tdata      (tdata),
      .i_s_axis_tlast      (tlast),
      .o_ppi_txrequesths   (txreq),
      .i_ppi_txreadyhs     (readyhs),
      .o_ppi_dl0_txdatahs  (dl0),
      .o_ppi_dl1_txdatahs  (dl1),
      .o_busy              (busy),
      .o_err_underflow     (errUnder),
      .o_err_length        (errLen)
   );

   // Records every accepted byte pair as {lane1, lane0}, HS cycles, bursts and hold violations
   wq_t capQ;
   int  reqCycles = 0;
   int  bursts = 0;
   int  unstable = 0;
   bit  prevHeld = 0;
   bit  prevReq = 0;
   logic [15:0] prevData = 16'h0;
   always @(negedge clock) begin
      if (txreq) begin
         reqCycles++;
         if (!prevReq) bursts++;
         if (prevHeld && {dl1, dl0} !== prevData) unstable++;
         if (readyhs) capQ.push_back({dl1, dl0});
         prevHeld = !readyhs;
         prevData = {dl1, dl0};
      end else begin
         prevHeld = 0;
      end
      prevReq = txreq;
   end

   // Reflected CRC-16/0x8408, fed one bit at a time: lane0 bits LSB-first, then lane1
   function automatic logic [15:0] crcModel(input wq_t pay);
      logic [15:0] c;
      logic fb;
      c = 16'hFFFF;
      foreach (pay[i]) begin
         for (int b = 0; b < 16; b++) begin
            fb = c[0] ^ pay[i][b];
            c = c >> 1;
            if (fb) c = c ^ 16'h8408;
         end
      end
      return c;
   endfunction

   // Expected long packet for DI=0x2A, WC=24 (hand-computed ECC 0x13)
   function automatic wq_t buildPkt(input wq_t pay);
      wq_t p;
      p.push_back(16'h182A);
      p.push_back(16'h1300);
      foreach (pay[i]) p.push_back(pay[i]);
      p.push_back(crcModel(pay));
      return p;
   endfunction

   task automatic loadCleanLine();
      srcData.delete();
      for (int i = 0; i < 12; i++) srcData.push_back(lineBeats[i]);
      srcLastIdx = 11;
      srcIdx = 0;
      dropIdx = -1;
      dropLeft = 0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tvalid = 0; tlast = 0; fsReq = 0; feReq = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   // Drives readyhs and the source each cycle until the DUT has been busy and returns idle
   task automatic runTraffic(input int maxCycles, output bit done);
      bit started;
      started = 0;
      done = 0;
      for (int c = 0; c < maxCycles; c++) begin
         readyhs = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (srcIdx < srcData.size() && !(srcIdx == dropIdx && dropLeft > 0)) begin
            tvalid = 1; tdata = srcData[srcIdx]; tlast = (srcIdx == srcLastIdx);
         end else begin
            tvalid = 0; tdata = 16'h0; tlast = 0;
         end
         @(negedge clock);
         if (tvalid && tready) srcIdx++;
         else if (!tvalid && srcIdx == dropIdx && dropLeft > 0) dropLeft--;
         if (busy) started = 1;
         if (started && !busy && srcIdx >= srcData.size()) begin
            done = 1;
            break;
         end
         @(posedge clock);
         #1;
      end
      tvalid = 0;
      tlast = 0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clock);
      checks++; if (txreq !== 1'b0) begin errors++; $display("[TB] FAIL reset_txreq: got %b expected 0", txreq); end
      checks++; if ({dl1, dl0} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_lanes: got %h expected 0000", {dl1, dl0}); end
      checks++; if (tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready: got %b expected 0", tready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if ({errUnder, errLen} !== 2'b00) begin errors++; $display("[TB] FAIL reset_errors: got %b expected 00", {errUnder, errLen}); end
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_frame_markers();
      int base, rc, bb;
      bit done;
      srcData.delete(); srcIdx = 0;
      base = capQ.size(); rc = reqCycles; bb = bursts;
      fsReq = 1; @(posedge clock); #1 fsReq = 0;
      runTraffic(20, done);
      checks++; if (!done) begin errors++; $display("[TB] FAIL fs_timeout: got done=%b expected 1", done); end
      checks++; if (reqCycles - rc !== 2 || bursts - bb !== 1) begin errors++;
         $display("[TB] FAIL fs_burst: got %0d cycles %0d bursts expected 2 cycles 1 burst", reqCycles - rc, bursts - bb); end
      checks++; if (capQ.size() - base !== 2 || capQ[base] !== 16'h0000 || capQ[base+1] !== 16'h0000) begin errors++;
         $display("[TB] FAIL fs_bytes: got %0d pairs first %h expected 2 pairs 0000,0000", capQ.size() - base, capQ[base]); end
      base = capQ.size(); rc = reqCycles;
      feReq = 1; @(posedge clock); #1 feReq = 0;
      runTraffic(20, done);
      checks++; if (reqCycles - rc !== 2) begin errors++; $display("[TB] FAIL fe_len: got %0d expected 2", reqCycles - rc); end
      checks++; if (capQ.size() - base !== 2 || capQ[base] !== 16'h0001 || capQ[base+1] !== 16'h0700) begin errors++;
         $display("[TB] FAIL fe_bytes: got %0d pairs %h,%h expected 0001,0700", capQ.size() - base, capQ[base], capQ[base+1]); end
   endtask

   task automatic test_long_line();
      int base, rc, bad;
      bit done;
      wq_t pay, exp;
      loadCleanLine();
      for (int i = 0; i < 12; i++) pay.push_back(lineBeats[i]);
      exp = buildPkt(pay);
      base = capQ.size(); rc = reqCycles;
      runTraffic(100, done);
      checks++; if (!done || reqCycles - rc !== 15) begin errors++;
         $display("[TB] FAIL long_len: got %0d cycles done=%b expected 15", reqCycles - rc, done); end
      checks++; if (capQ.size() - base !== 15) begin errors++; $display("[TB] FAIL long_count: got %0d expected 15", capQ.size() - base); end
      checks++; if (capQ.size() >= base + 15 && capQ[base+14] !== 16'h00F0) begin errors++;
         $display("[TB] FAIL long_footer: got %h expected 00F0", capQ[base+14]); end
      checks++; bad = 0;
      for (int k = 0; k < 15; k++)
         if (base + k < capQ.size() && capQ[base+k] !== exp[k]) begin bad++;
            $display("[TB] FAIL long_seq[%0d]: got %h expected %h", k, capQ[base+k], exp[k]); end
      if (bad != 0) errors++;
      checks++; if ({errUnder, errLen} !== 2'b00) begin errors++; $display("[TB] FAIL long_errors: got %b expected 00", {errUnder, errLen}); end
   endtask

   task automatic test_ready_toggle();
      int base, un, bad;
      bit done;
      wq_t pay, exp;
      loadCleanLine();
      for (int i = 0; i < 12; i++) pay.push_back(lineBeats[i]);
      exp = buildPkt(pay);
      base = capQ.size(); un = unstable;
      randReady = 1;
      runTraffic(300, done);
      randReady = 0;
      checks++; if (!done || capQ.size() - base !== 15) begin errors++;
         $display("[TB] FAIL toggle_count: got %0d done=%b expected 15", capQ.size() - base, done); end
      checks++; bad = 0;
      for (int k = 0; k < 15; k++)
         if (base + k < capQ.size() && capQ[base+k] !== exp[k]) begin bad++;
            $display("[TB] FAIL toggle_seq[%0d]: got %h expected %h", k, capQ[base+k], exp[k]); end
      if (bad != 0) errors++;
      checks++; if (unstable - un !== 0) begin errors++; $display("[TB] FAIL toggle_hold: got %0d changes expected 0", unstable - un); end
   endtask

   task automatic test_underflow();
      int base, bad;
      bit done;
      wq_t pay, exp;
      doReset();
      srcData.delete();
      for (int i = 0; i < 10; i++) srcData.push_back(lineBeats[i]);
      srcLastIdx = 9; srcIdx = 0; dropIdx = 5; dropLeft = 2;
      for (int i = 0; i < 5; i++) pay.push_back(lineBeats[i]);
      pay.push_back(16'h0000); pay.push_back(16'h0000);
      for (int i = 5; i < 10; i++) pay.push_back(lineBeats[i]);
      exp = buildPkt(pay);
      base = capQ.size();
      runTraffic(100, done);
      checks++; if (!done || capQ.size() - base !== 15) begin errors++;
         $display("[TB] FAIL under_count: got %0d done=%b expected 15", capQ.size() - base, done); end
      checks++; bad = 0;
      for (int k = 0; k < 15; k++)
         if (base + k < capQ.size() && capQ[base+k] !== exp[k]) begin bad++;
            $display("[TB] FAIL under_seq[%0d]: got %h expected %h", k, capQ[base+k], exp[k]); end
      if (bad != 0) errors++;
      checks++; if ({errUnder, errLen} !== 2'b10) begin errors++; $display("[TB] FAIL under_flags: got %b expected 10", {errUnder, errLen}); end
   endtask

   task automatic test_short_line_padding();
      int base, bad;
      bit done;
      wq_t pay, exp;
      doReset();
      srcData.delete();
      for (int i = 0; i < 10; i++) srcData.push_back(lineBeats[i]);
      srcLastIdx = 9; srcIdx = 0; dropIdx = -1; dropLeft = 0;
      for (int i = 0; i < 10; i++) pay.push_back(lineBeats[i]);
      pay.push_back(16'h0000); pay.push_back(16'h0000);
      exp = buildPkt(pay);
      base = capQ.size();
      runTraffic(100, done);
      checks++; if (!done || capQ.size() - base !== 15) begin errors++;
         $display("[TB] FAIL pad_count: got %0d done=%b expected 15", capQ.size() - base, done); end
      checks++; bad = 0;
      for (int k = 0; k < 15; k++)
         if (base + k < capQ.size() && capQ[base+k] !== exp[k]) begin bad++;
            $display("[TB] FAIL pad_seq[%0d]: got %h expected %h", k, capQ[base+k], exp[k]); end
      if (bad != 0) errors++;
      checks++; if ({errUnder, errLen} !== 2'b01) begin errors++; $display("[TB] FAIL pad_flags: got %b expected 01", {errUnder, errLen}); end
   endtask

   task automatic test_overlong_line();
      int base;
      bit done;
      doReset();
      loadCleanLine();
      srcData.push_back(16'h1111);
      srcData.push_back(16'h2222);
      srcLastIdx = 13;
      base = capQ.size();
      runTraffic(100, done);
      checks++; if (!done || srcIdx !== 14) begin errors++;
         $display("[TB] FAIL long_discard: got %0d beats consumed done=%b expected 14", srcIdx, done); end
      checks++; if (capQ.size() - base !== 15 || capQ[base+14] !== 16'h00F0) begin errors++;
         $display("[TB] FAIL long_discard_pkt: got %0d pairs footer %h expected 15 and 00F0", capQ.size() - base, capQ[base+14]); end
      checks++; if ({errUnder, errLen} !== 2'b01) begin errors++; $display("[TB] FAIL long_discard_flags: got %b expected 01", {errUnder, errLen}); end
      loadCleanLine();
      base = capQ.size();
      runTraffic(100, done);
      checks++; if (!done || capQ.size() - base !== 15 || capQ[base] !== 16'h182A || capQ[base+14] !== 16'h00F0) begin errors++;
         $display("[TB] FAIL next_line: got %0d pairs hdr %h footer %h expected 15, 182A, 00F0", capQ.size() - base, capQ[base], capQ[base+14]); end
      checks++; if (errUnder !== 1'b0) begin errors++; $display("[TB] FAIL next_line_under: got %b expected 0", errUnder); end
   endtask

   task automatic test_back_to_back();
      int base, bb;
      bit d1, d2;
      doReset();
      loadCleanLine();
      base = capQ.size(); bb = bursts;
      fsReq = 1; feReq = 1; @(posedge clock); #1 fsReq = 0; feReq = 0;
      runTraffic(100, d1);
      runTraffic(30, d2);
      checks++; if (!(d1 && d2) || bursts - bb !== 3) begin errors++;
         $display("[TB] FAIL b2b_bursts: got %0d bursts done=%b%b expected 3", bursts - bb, d1, d2); end
      checks++; if (capQ.size() - base !== 19) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 19", capQ.size() - base); end
      else begin
         checks++; if (capQ[base] !== 16'h0000 || capQ[base+1] !== 16'h0000) begin errors++;
            $display("[TB] FAIL b2b_fs_first: got %h,%h expected 0000,0000", capQ[base], capQ[base+1]); end
         checks++; if (capQ[base+2] !== 16'h182A || capQ[base+16] !== 16'h00F0) begin errors++;
            $display("[TB] FAIL b2b_line_second: got %h..%h expected 182A..00F0", capQ[base+2], capQ[base+16]); end
         checks++; if (capQ[base+17] !== 16'h0001 || capQ[base+18] !== 16'h0700) begin errors++;
            $display("[TB] FAIL b2b_fe_last: got %h,%h expected 0001,0700", capQ[base+17], capQ[base+18]); end
      end
   endtask

   task automatic test_pending_absorb();
      int base, bb;
      bit d1, d2;
      doReset();
      loadCleanLine();
      base = capQ.size(); bb = bursts;
      fork
         runTraffic(100, d1);
         begin
            repeat (5) @(posedge clock);
            #1 fsReq = 1; @(posedge clock); #1 fsReq = 0;
            @(posedge clock); #1 fsReq = 1; @(posedge clock); #1 fsReq = 0;
         end
      join
      runTraffic(30, d2);
      repeat (10) @(posedge clock);
      #1;
      checks++; if (!(d1 && d2) || bursts - bb !== 2 || capQ.size() - base !== 17) begin errors++;
         $display("[TB] FAIL absorb: got %0d bursts %0d pairs expected 2 bursts 17 pairs", bursts - bb, capQ.size() - base); end
   endtask

   task automatic test_reset_mid_packet();
      int bb;
      bit done;
      doReset();
      loadCleanLine();
      runTraffic(6, done);
      feReq = 1; @(posedge clock); #1 feReq = 0;
      #2 reset = 1'b1;
      #1;
      checks++; if (txreq !== 1'b0) begin errors++; $display("[TB] FAIL midreset_txreq: got %b expected 0", txreq); end
      checks++; if (busy !== 1'b0 || {dl1, dl0} !== 16'h0000) begin errors++;
         $display("[TB] FAIL midreset_state: got busy %b lanes %h expected 0, 0000", busy, {dl1, dl0}); end
      tvalid = 0;
      @(posedge clock);
      #1 reset = 1'b0;
      bb = bursts;
      repeat (8) @(posedge clock);
      #1;
      checks++; if (busy !== 1'b0 || bursts - bb !== 0) begin errors++;
         $display("[TB] FAIL midreset_resume: got busy %b bursts %0d expected 0, 0", busy, bursts - bb); end
      checks++; if ({errUnder, errLen} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_errors: got %b expected 00", {errUnder, errLen}); end
   endtask

   initial begin
      fsReq = 0; feReq = 0; tvalid = 0; tlast = 0; tdata = 16'h0; readyhs = 1'b1;
      cfgDt = 6'h2A; cfgWc = 16'd24;
      test_reset();
      test_frame_markers();
      test_long_line();
      test_ready_toggle();
      test_underflow();
      test_short_line_padding();
      test_overlong_line();
      test_back_to_back();
      test_pending_absorb();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
